// File: rtl/rx_pkg.sv
// Shared definitions for the RX descrambler sequencer: FSM encoding, ordered-set symbols
// and lane count.
package rx_pkg;

   localparam int unsigned NUM_LANES = 16;

   localparam logic [7:0] COM_SYM     = 8'hBC;
   localparam logic [1:0] OS_SYNC_HDR = 2'b01;

   typedef enum logic [1:0] {
      ScrOff    = 2'd0,
      ScrArm    = 2'd1,
      ScrOn     = 2'd2,
      ScrReseed = 2'd3
   } scr_state_e;

endpackage

// File: rtl/rx_lane_bypass_ctrl.sv
// Single-lane ordered-set bypass tracker: Gen1/2 COM hold counter, Gen3+ OS-block flag and
// LFSR reset pulse on COM.
module rx_lane_bypass_ctrl
   import rx_pkg::*;
#(
   parameter int unsigned OS_HOLD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       gen_change,
   input  logic       low_rate,
   input  logic       active,
   input  logic       valid,
   input  logic [7:0] sym,
   input  logic       sym_k,
   input  logic       start_block,
   input  logic [1:0] sync_hdr,
   output logic       bypass_next,
   output logic       lfsr_reset
);

   localparam logic [3:0] HoldLoad = 4'(OS_HOLD);

   logic [3:0] hold_q, hold_d;
   logic       os_q, os_d;
   logic       com;

   always_comb begin
      com    = active && low_rate && valid && sym_k && (sym == COM_SYM);
      hold_d = hold_q;
      os_d   = os_q;
      // A rate change discards any ordered-set context, even a COM on the same cycle.
      if (!active || gen_change) begin
         hold_d = 4'd0;
         os_d   = 1'b0;
      end else if (low_rate) begin
         if (com) begin
            hold_d = HoldLoad;
         end else if (valid && (hold_q != 4'd0)) begin
            hold_d = hold_q - 4'd1;
         end
      end else if (valid && start_block) begin
         os_d = (sync_hdr == OS_SYNC_HDR);
      end
      bypass_next = low_rate ? (hold_d != 4'd0) : os_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q     <= 4'd0;
         os_q       <= 1'b0;
         lfsr_reset <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         os_q       <= os_d;
         lfsr_reset <= com;
      end
   end

endmodule

// File: rtl/rx_descrambler_sequencer.sv
// Sequences the 16 RX descramblers: enable FSM, rate-change reseed and per-lane OS bypass.
// Optional statistics outputs are built when RX_DESCR_SEQ_STATS_EN is defined.
module rx_descrambler_sequencer
   import rx_pkg::*;
#(
   parameter int unsigned DEVICETYPE        = 0,
   parameter int unsigned CFG_IDLE_SUBSTATE = 9,
   parameter int unsigned ARM_DELAY         = 2,
   parameter int unsigned OS_HOLD           = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [2:0]   GEN,
   input  logic [4:0]   substate,
   input  logic         disableScrambler,
   input  logic [4:0]   numberOfDetectedLanes,
   input  logic [15:0]  PIPEDataValid,
   input  logic [127:0] laneSym0,
   input  logic [15:0]  laneSym0K,
   input  logic [15:0]  PIPEStartBlock,
   input  logic [31:0]  PIPESyncHeader,
   output logic [15:0]  descrTurnOff,
   output logic [15:0]  lfsrReset,
   output logic         seedLoad,
   output logic [1:0]   scrState,
   output logic         scrActive
`ifdef RX_DESCR_SEQ_STATS_EN
   ,
   output logic [15:0]  osBypassCount,
   output logic [7:0]   reseedCount
`endif
);

   localparam logic [2:0] ArmLast = 3'(ARM_DELAY - 1);
   localparam logic [4:0] CfgIdle = 5'(CFG_IDLE_SUBSTATE);

   scr_state_e state_q, state_d;
   logic [2:0] arm_q, arm_d;
   logic [2:0] gen_q;
   logic       gen_change;
   logic       low_rate;
   logic       cfg_idle;

   logic [NUM_LANES-1:0] lane_active;
   logic [NUM_LANES-1:0] bypass_next;
   logic [NUM_LANES-1:0] turnoff_d;

   assign gen_change = (GEN != gen_q);
   assign low_rate   = (GEN <= 3'd2);
   assign cfg_idle   = (substate == CfgIdle);

   always_comb begin
      state_d = state_q;
      arm_d   = arm_q;
      if (disableScrambler) begin
         state_d = ScrOff;
      end else begin
         case (state_q)
            ScrOff: begin
               if (cfg_idle) begin
                  if (DEVICETYPE == 1) begin
                     state_d = ScrOn;
                  end else begin
                     state_d = ScrArm;
                     arm_d   = 3'd0;
                  end
               end
            end
            ScrArm: begin
               // armCnt survives excursions out of Configuration.Idle.
               if (cfg_idle) begin
                  if (arm_q >= ArmLast) begin
                     state_d = ScrOn;
                  end else if (arm_q != 3'd7) begin
                     arm_d = arm_q + 3'd1;
                  end
               end
            end
            ScrOn: begin
               if (gen_change) begin
                  state_d = ScrReseed;
               end
            end
            ScrReseed: state_d = ScrOn;
            default:   state_d = ScrOff;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign lane_active[g] = (numberOfDetectedLanes > 5'(g));

      rx_lane_bypass_ctrl #(
         .OS_HOLD(OS_HOLD)
      ) u_lane (
         .clk        (clk),
         .reset      (reset),
         .gen_change (gen_change),
         .low_rate   (low_rate),
         .active     (lane_active[g]),
         .valid      (PIPEDataValid[g]),
         .sym        (laneSym0[g*8+:8]),
         .sym_k      (laneSym0K[g]),
         .start_block(PIPEStartBlock[g]),
         .sync_hdr   (PIPESyncHeader[g*2+:2]),
         .bypass_next(bypass_next[g]),
         .lfsr_reset (lfsrReset[g])
      );

      assign turnoff_d[g] = (state_d != ScrOn) || bypass_next[g] || !lane_active[g];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ScrOff;
         arm_q        <= 3'd0;
         gen_q        <= GEN;
         descrTurnOff <= 16'hFFFF;
         seedLoad     <= 1'b0;
      end else begin
         state_q      <= state_d;
         arm_q        <= arm_d;
         gen_q        <= GEN;
         descrTurnOff <= turnoff_d;
         seedLoad     <= (state_d == ScrReseed);
      end
   end

   assign scrState  = state_q;
   assign scrActive = (state_q == ScrOn);

`ifdef RX_DESCR_SEQ_STATS_EN
   logic byp0_q;
   logic byp0_d;

   assign byp0_d = bypass_next[0] && lane_active[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         byp0_q        <= 1'b0;
         osBypassCount <= 16'd0;
         reseedCount   <= 8'd0;
      end else begin
         byp0_q <= byp0_d;
         if (byp0_d && !byp0_q && (osBypassCount != 16'hFFFF)) begin
            osBypassCount <= osBypassCount + 16'd1;
         end
         if ((state_d == ScrReseed) && (reseedCount != 8'hFF)) begin
            reseedCount <= reseedCount + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rx_descrambler_sequencer.sv
// Bench for rx_descrambler_sequencer: a downstream and an upstream instance share stimulus and
// are compared every cycle against a behavioural model of the sequencing rules.
module tb_rx_descrambler_sequencer;

   localparam int CFG       = 9;
   localparam int ARM_DELAY = 2;
   localparam int OS_HOLD   = 4;

   logic         clk;
   logic         reset;
   logic [2:0]   gen;
   logic [4:0]   substate;
   logic         dis;
   logic [4:0]   nlanes;
   logic [15:0]  valid;
   logic [127:0] sym;
   logic [15:0]  symk;
   logic [15:0]  sb;
   logic [31:0]  hdr;

   logic [15:0] t_off  [2];
   logic [15:0] t_lfsr [2];
   logic        t_seed [2];
   logic [1:0]  t_state[2];
   logic        t_act  [2];

   int vectors;
   int miscompares;
   int cyc;

   // Model state: index 0 = downstream instance, 1 = upstream instance.
   int          m_state[2];
   int          m_arm  [2];
   int          m_genq [2];
   int          m_hold [2][16];
   bit          m_os   [2][16];
   logic [15:0] e_off  [2];
   logic [15:0] e_lfsr [2];
   logic        e_seed [2];

   rx_descrambler_sequencer #(
      .DEVICETYPE(0), .CFG_IDLE_SUBSTATE(CFG), .ARM_DELAY(ARM_DELAY), .OS_HOLD(OS_HOLD)
   ) u_dsp (
      .clk(clk), .reset(reset), .GEN(gen), .substate(substate), .disableScrambler(dis),
      .numberOfDetectedLanes(nlanes), .PIPEDataValid(valid), .laneSym0(sym),
      .laneSym0K(symk), .PIPEStartBlock(sb), .PIPESyncHeader(hdr),
      .descrTurnOff(t_off[0]), .lfsrReset(t_lfsr[0]), .seedLoad(t_seed[0]),
      .scrState(t_state[0]), .scrActive(t_act[0])
   );

   rx_descrambler_sequencer #(
      .DEVICETYPE(1), .CFG_IDLE_SUBSTATE(CFG), .ARM_DELAY(ARM_DELAY), .OS_HOLD(OS_HOLD)
   ) u_usp (
      .clk(clk), .reset(reset), .GEN(gen), .substate(substate), .disableScrambler(dis),
      .numberOfDetectedLanes(nlanes), .PIPEDataValid(valid), .laneSym0(sym),
      .laneSym0K(symk), .PIPEStartBlock(sb), .PIPESyncHeader(hdr),
      .descrTurnOff(t_off[1]), .lfsrReset(t_lfsr[1]), .seedLoad(t_seed[1]),
      .scrState(t_state[1]), .scrActive(t_act[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step(input int d, input int dev);
      int nxt;
      bit chg;
      bit act;
      bit com;
      bit byp;
      if (reset) begin
         m_state[d] = 0;
         m_arm[d]   = 0;
         m_genq[d]  = int'(gen);
         for (int i = 0; i < 16; i++) begin
            m_hold[d][i] = 0;
            m_os[d][i]   = 0;
         end
         e_off[d]  = 16'hFFFF;
         e_lfsr[d] = 16'h0000;
         e_seed[d] = 1'b0;
      end else begin
         chg = (int'(gen) != m_genq[d]);
         nxt = m_state[d];
         if (dis) begin
            nxt = 0;
         end else if (m_state[d] == 0) begin
            if (int'(substate) == CFG) begin
               if (dev == 1) nxt = 2;
               else begin
                  nxt = 1;
                  m_arm[d] = 0;
               end
            end
         end else if (m_state[d] == 1) begin
            if (int'(substate) == CFG) begin
               if (m_arm[d] >= ARM_DELAY - 1) nxt = 2;
               else m_arm[d]++;
            end
         end else if (m_state[d] == 2) begin
            if (chg) nxt = 3;
         end else begin
            nxt = 2;
         end
         m_state[d] = nxt;
         m_genq[d]  = int'(gen);
         for (int i = 0; i < 16; i++) begin
            act = (i < int'(nlanes));
            com = act && (gen <= 3'd2) && valid[i] && symk[i] && (sym[i*8+:8] == 8'hBC);
            if (!act || chg) begin
               m_hold[d][i] = 0;
               m_os[d][i]   = 0;
            end else if (gen <= 3'd2) begin
               if (com) m_hold[d][i] = OS_HOLD;
               else if (valid[i] && m_hold[d][i] > 0) m_hold[d][i]--;
            end else if (valid[i] && sb[i]) begin
               m_os[d][i] = (hdr[i*2+:2] == 2'b01);
            end
            byp          = (gen <= 3'd2) ? (m_hold[d][i] > 0) : m_os[d][i];
            e_lfsr[d][i] = com;
            e_off[d][i]  = (nxt != 2) || !act || byp;
         end
         e_seed[d] = (nxt == 3);
      end
   endtask

   task automatic step();
      model_step(0, 0);
      model_step(1, 1);
      @(posedge clk);
      #1;
      cyc++;
      check("dsp_state",  32'(t_state[0]), 32'(m_state[0]));
      check("dsp_active", 32'(t_act[0]),   32'(m_state[0] == 2));
      check("dsp_off",    32'(t_off[0]),   32'(e_off[0]));
      check("dsp_lfsr",   32'(t_lfsr[0]),  32'(e_lfsr[0]));
      check("dsp_seed",   32'(t_seed[0]),  32'(e_seed[0]));
      check("usp_state",  32'(t_state[1]), 32'(m_state[1]));
      check("usp_active", 32'(t_act[1]),   32'(m_state[1] == 2));
      check("usp_off",    32'(t_off[1]),   32'(e_off[1]));
      check("usp_lfsr",   32'(t_lfsr[1]),  32'(e_lfsr[1]));
      check("usp_seed",   32'(t_seed[1]),  32'(e_seed[1]));
   endtask

   task automatic quiet_lanes();
      valid = 16'hFFFF;
      sym   = '0;
      symk  = '0;
      sb    = '0;
      hdr   = '0;
   endtask

   task automatic put_com(input int lane);
      sym[lane*8+:8] = 8'hBC;
      symk[lane]     = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      reset       = 1'b1;
      gen         = 3'd1;
      substate    = 5'd0;
      dis         = 1'b0;
      nlanes      = 5'd4;
      quiet_lanes();
      step();
      step();
      check("reset_off", 32'(t_off[0]), 32'h0000FFFF);
      reset = 1'b0;

      // Enable: downstream arms first, upstream turns on immediately.
      substate = 5'(CFG);
      step();
      check("dsp_arm_first", 32'(t_state[0]), 32'd1);
      check("usp_on_first",  32'(t_state[1]), 32'd2);
      repeat (4) step();
      check("dsp_mask4", 32'(t_off[0]), 32'h0000FFF0);

      // Gen1 COM on lane 2, re-armed by a second COM two cycles later.
      put_com(2);
      step();
      check("com_lfsr", 32'(t_lfsr[0]), 32'h00000004);
      quiet_lanes();
      step();
      valid[2] = 1'b0;
      step();
      valid[2] = 1'b1;
      put_com(2);
      step();
      quiet_lanes();
      repeat (6) step();

      // Gen3 ordered-set blocks on lane 0; a COM-like byte must not reset the LFSR.
      gen = 3'd3;
      repeat (3) step();
      sb[0] = 1'b1;
      hdr[1:0] = 2'b01;
      put_com(1);
      step();
      quiet_lanes();
      repeat (3) step();
      sb[0] = 1'b1;
      hdr[1:0] = 2'b10;
      step();
      quiet_lanes();
      step();

      // Rate change in ON.
      gen = 3'd4;
      repeat (3) step();

      // Disable in ON, then a rate change while the downstream instance is in ARM.
      dis = 1'b1;
      put_com(3);
      step();
      quiet_lanes();
      dis = 1'b0;
      substate = 5'd0;
      step();
      substate = 5'(CFG);
      step();
      substate = 5'd0;
      gen = 3'd5;
      repeat (2) step();
      substate = 5'(CFG);
      repeat (4) step();

      // Disable while in RESEED.
      gen = 3'd2;
      step();
      dis = 1'b1;
      step();
      dis = 1'b0;
      repeat (4) step();

      // Reset in the middle of a hold.
      nlanes = 5'd16;
      put_com(0);
      step();
      quiet_lanes();
      step();
      reset = 1'b1;
      step();
      check("midreset_off", 32'(t_off[1]), 32'h0000FFFF);
      reset = 1'b0;

      // COM together with a rate change.
      repeat (3) step();
      gen = 3'd1;
      put_com(5);
      step();
      quiet_lanes();
      repeat (2) step();

      // Randomised traffic.
      for (int n = 0; n < 800; n++) begin
         reset    = ($urandom_range(0, 99) == 0);
         dis      = ($urandom_range(0, 19) == 0);
         substate = ($urandom_range(0, 9) < 6) ? 5'(CFG) : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 24) == 0) gen = 3'($urandom_range(1, 5));
         if ($urandom_range(0, 49) == 0) begin
            case ($urandom_range(0, 5))
               0: nlanes = 5'd0;
               1: nlanes = 5'd1;
               2: nlanes = 5'd2;
               3: nlanes = 5'd4;
               4: nlanes = 5'd8;
               default: nlanes = 5'd16;
            endcase
         end
         for (int i = 0; i < 16; i++) begin
            valid[i]       = ($urandom_range(0, 9) < 8);
            sym[i*8+:8]    = ($urandom_range(0, 6) == 0) ? 8'hBC : 8'($urandom_range(0, 255));
            symk[i]        = ($urandom_range(0, 2) == 0);
            sb[i]          = ($urandom_range(0, 4) == 0);
            hdr[i*2+:2]    = 2'($urandom_range(0, 3));
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
